router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
Control FSM for the 1x3 router input side. It decodes the destination address from the header byte and sequences the header, payload and parity writes. It drives the state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) consumed by Router_Register. It also generates write_enb_reg for the three output FIFOs and busy back-pressure to the packet source.

Parameters:
NUM_PORTS, 3, number of destination FIFOs; the address field is datain[1:0], and address 3 is invalid.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-low reset
packet_valid  in  1  source asserts for header+payload, drops on parity byte
datain  in  2  header address bits (datain[1:0] of input byte)
fifo_full  in  1  full flag of currently selected FIFO
fifo_empty  in  NUM_PORTS  per-FIFO empty flags, bit i = FIFO i
soft_reset  in  NUM_PORTS  per-FIFO timeout soft reset
parity_done  in  1  from Router_Register
low_packet_valid  in  1  from Router_Register
write_enb_reg  out  1  write enable to output FIFO stage
detect_add  out  1  DECODE_ADDRESS active
lfd_state  out  1  LOAD_FIRST_DATA active
ld_state  out  1  LOAD_DATA active
laf_state  out  1  LOAD_AFTER_FULL active
full_state  out  1  FIFO_FULL_STATE active
rst_int_reg  out  1  CHECK_PARITY_ERROR active
busy  out  1  source must hold current byte
addr_q  out  2  latched destination address

Behaviour:
- Moore machine; all outputs decode from the registered state only. State register is 3 bits and one-hot is not required.
- Reset: rst=0 sampled at a rising edge forces DECODE_ADDRESS and addr_q=0. Resulting outputs: detect_add=1, all other strobes 0, busy=0, write_enb_reg=0. This applies mid-packet too; no partial state is retained.
- Address latch: addr_q<=datain when state==DECODE_ADDRESS && packet_valid && datain!=3; otherwise it holds.
- Transitions (soft_reset[addr_q]=1 in any state except DECODE_ADDRESS has top priority -> DECODE_ADDRESS):
  DECODE_ADDRESS: on packet_valid && datain!=3 && fifo_empty[datain] -> LOAD_FIRST_DATA. On packet_valid && datain!=3 && !fifo_empty[datain] -> WAIT_TILL_EMPTY. On datain==3 it stays, and the packet is ignored.
  WAIT_TILL_EMPTY (busy=1): on fifo_empty[addr_q] -> LOAD_FIRST_DATA.
  LOAD_FIRST_DATA (lfd_state=1, busy=1): always -> LOAD_DATA.
  LOAD_DATA (ld_state=1, write_enb_reg=1, busy=0): on fifo_full -> FIFO_FULL_STATE; else on !packet_valid -> LOAD_PARITY; else it stays. fifo_full has priority over !packet_valid.
  FIFO_FULL_STATE (full_state=1, busy=1, write_enb_reg=0): on !fifo_full -> LOAD_AFTER_FULL.
  LOAD_AFTER_FULL (laf_state=1, busy=1, write_enb_reg=1): on parity_done -> DECODE_ADDRESS; else on low_packet_valid -> LOAD_PARITY; else -> LOAD_DATA.
  LOAD_PARITY (busy=1, write_enb_reg=1): always -> CHECK_PARITY_ERROR.
  CHECK_PARITY_ERROR (rst_int_reg=1, busy=1): on fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- write_enb_reg is 0 in DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, FIFO_FULL_STATE and CHECK_PARITY_ERROR. The header write is issued by Router_Register from its latched header during LOAD_FIRST_DATA, via the lfd-qualified path downstream.
- Latency: header accepted in DECODE_ADDRESS at cycle 0 gives lfd_state=1 at cycle 1 and ld_state=1 at cycle 2 (empty FIFO case).
- soft_reset of a non-selected FIFO is ignored.
- Unreachable state encodings recover to DECODE_ADDRESS.

Optional Feature:
ROUTER_FSM_PKT_CNT_EN:
- Defined: adds output pkt_count[15:0]. It is reset to 0 by rst and increments by 1 on each CHECK_PARITY_ERROR -> any transition, wrapping 0xFFFF -> 0. It also adds drop_count[7:0], which increments in DECODE_ADDRESS on packet_valid && datain==3 and saturates at 0xFF.
- Undefined: neither port nor register exists.

Decomposition:
- Package router_pkg: state enum/localparams (DECODE_ADDRESS=0 ... CHECK_PARITY_ERROR=7), ADDR_INVALID=2'd3, NUM_PORTS.
- No sub-module. The state register, next-state logic and output decode live in one module. Counters under the macro are inline.

Test Plan:
- Reset: hold rst=0 for 1 cycle mid-LOAD_DATA -> next cycle detect_add=1, ld_state=0, busy=0, addr_q=0.
- Normal packet: fifo_empty=3'b111, header datain=2'b10 with 8 payload bytes, then packet_valid=0. Expected sequence: detect_add, lfd_state (1 cycle), ld_state for 8 cycles, LOAD_PARITY, rst_int_reg (1 cycle), then DECODE_ADDRESS; addr_q=2.
- Wait-empty: fifo_empty=3'b011, header addr 2 -> WAIT_TILL_EMPTY with busy=1 until fifo_empty[2]=1, then lfd_state=1 the next cycle.
- Full mid-payload: fifo_full=1 during LOAD_DATA -> full_state=1, write_enb_reg=0. Release fifo_full: with low_packet_valid=1 it goes laf_state to LOAD_PARITY; with parity_done=1 it goes laf_state to DECODE_ADDRESS.
- Soft reset: soft_reset=3'b100 with addr_q=2 in LOAD_DATA -> DECODE_ADDRESS next cycle. soft_reset=3'b001 with the same addr_q has no effect.
- Invalid address: header datain=2'b11 with packet_valid=1 -> the FSM stays in DECODE_ADDRESS and write_enb_reg stays 0. With ROUTER_FSM_PKT_CNT_EN, drop_count goes 0 -> 1.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router input-side control FSM.
package router_pkg;

    localparam int         NUM_PORTS    = 3;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

endpackage

// File: rtl/router_fsm.sv
// Moore control FSM for the 1x3 router input side: address decode, payload/parity sequencing.
// Optional packet/drop counters are enabled by defining ROUTER_FSM_PKT_CNT_EN.
module router_fsm
    import router_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 packet_valid,
    input  logic [1:0]           datain,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_packet_valid,
    output logic                 write_enb_reg,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic [1:0]           addr_q
`ifdef ROUTER_FSM_PKT_CNT_EN
    ,
    output logic [15:0]          pkt_count,
    output logic [7:0]           drop_count
`endif
);

    state_e     state_q, state_d;
    logic [1:0] addr_d;
    logic [3:0] emptyVec;
    logic [3:0] softVec;
    logic       headerOk;

    // Padding to four entries lets the 2-bit address index safely; slot 3 is never selected.
    assign emptyVec = {1'b0, fifo_empty};
    assign softVec  = {1'b0, soft_reset};
    assign headerOk = packet_valid && (datain != ADDR_INVALID);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (headerOk) begin
                    addr_d  = datain;
                    state_d = emptyVec[datain] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY:    if (emptyVec[addr_q]) state_d = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)          state_d = FIFO_FULL_STATE;
                else if (!packet_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE:    if (!fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (parity_done)           state_d = DECODE_ADDRESS;
                else if (low_packet_valid) state_d = LOAD_PARITY;
                else                       state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:            state_d = DECODE_ADDRESS;
        endcase
        // A timeout on the selected FIFO abandons the packet from any active state.
        if ((state_q != DECODE_ADDRESS) && softVec[addr_q]) state_d = DECODE_ADDRESS;
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        write_enb_reg = 1'b0;
        case (state_q)
            DECODE_ADDRESS:     detect_add = 1'b1;
            WAIT_TILL_EMPTY:    busy = 1'b1;
            LOAD_FIRST_DATA:    begin lfd_state = 1'b1; busy = 1'b1; end
            LOAD_DATA:          begin ld_state = 1'b1; write_enb_reg = 1'b1; end
            FIFO_FULL_STATE:    begin full_state = 1'b1; busy = 1'b1; end
            LOAD_AFTER_FULL:    begin laf_state = 1'b1; busy = 1'b1; write_enb_reg = 1'b1; end
            LOAD_PARITY:        begin busy = 1'b1; write_enb_reg = 1'b1; end
            CHECK_PARITY_ERROR: begin rst_int_reg = 1'b1; busy = 1'b1; end
            default:            detect_add = 1'b1;
        endcase
    end

`ifdef ROUTER_FSM_PKT_CNT_EN
    logic [15:0] pkt_count_q;
    logic [7:0]  drop_count_q;

    // CHECK_PARITY_ERROR is always left after one cycle, so each visit counts one packet.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_count_q  <= 16'd0;
            drop_count_q <= 8'd0;
        end else begin
            if (state_q == CHECK_PARITY_ERROR) pkt_count_q <= pkt_count_q + 16'd1;
            if ((state_q == DECODE_ADDRESS) && packet_valid && (datain == ADDR_INVALID)
                && (drop_count_q != 8'hFF))
                drop_count_q <= drop_count_q + 8'd1;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Directed scoreboard bench for router_fsm: expected Moore outputs queued per cycle, checked by a monitor.
module tb_router_fsm;

    localparam int S_DA = 0, S_WTE = 1, S_LFD = 2, S_LD = 3, S_FFS = 4, S_LAF = 5, S_LP = 6, S_CPE = 7;

    typedef struct {
        logic [9:0]  outs;
        string       name;
        logic        chkCnt;
        logic [15:0] pkt;
        logic [7:0]  drop;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       packet_valid = 1'b0;
    logic [1:0] datain = 2'd0;
    logic       fifo_full = 1'b0;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] soft_reset = 3'b000;
    logic       parity_done = 1'b0;
    logic       low_packet_valid = 1'b0;
    logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, busy;
    logic [1:0] addr_q;
    logic [15:0] pkt_count;
    logic [7:0]  drop_count;

    exp_t scoreQ[$];
    int   checks = 0;
    int   failures = 0;

    router_fsm dut (
        .clk(clk), .rst(rst), .packet_valid(packet_valid), .datain(datain),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_packet_valid(low_packet_valid),
        .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .busy(busy), .addr_q(addr_q)
`ifdef ROUTER_FSM_PKT_CNT_EN
        , .pkt_count(pkt_count), .drop_count(drop_count)
`endif
    );

`ifndef ROUTER_FSM_PKT_CNT_EN
    assign pkt_count  = 16'd0;
    assign drop_count = 8'd0;
`endif

    always #5 clk = ~clk;

    // Output vector order: detect, lfd, ld, laf, full, rst_int, busy, wen, addr[1:0].
    function automatic logic [9:0] expOuts(input int st, input logic [1:0] addr);
        logic [7:0] s;
        case (st)
            S_DA:    s = 8'b1000_0000;
            S_WTE:   s = 8'b0000_0010;
            S_LFD:   s = 8'b0100_0010;
            S_LD:    s = 8'b0010_0001;
            S_FFS:   s = 8'b0000_1010;
            S_LAF:   s = 8'b0001_0011;
            S_LP:    s = 8'b0000_0011;
            default: s = 8'b0000_0110;
        endcase
        return {s, addr};
    endfunction

    task automatic applyStimulus(input logic rstn, input logic pv, input logic [1:0] din,
                                 input logic full, input logic [2:0] empty, input logic [2:0] sr,
                                 input logic pd, input logic lpv,
                                 input int expState, input logic [1:0] expAddr, input string name);
        exp_t e;
        rst = rstn; packet_valid = pv; datain = din; fifo_full = full;
        fifo_empty = empty; soft_reset = sr; parity_done = pd; low_packet_valid = lpv;
        @(posedge clk);
        #1;
        e.outs = expOuts(expState, expAddr);
        e.name = name;
        e.chkCnt = 1'b0;
        e.pkt = 16'd0;
        e.drop = 8'd0;
        scoreQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [9:0] act;
        act = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               busy, write_enb_reg, addr_q};
        checks++;
        if (act !== e.outs) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", e.name, act, e.outs);
        end
        if (e.chkCnt) begin
            checks++;
            if (pkt_count !== e.pkt || drop_count !== e.drop) begin
                failures++;
                $display("[TB] FAIL %s: got pkt=%0d drop=%0d expected pkt=%0d drop=%0d",
                         e.name, pkt_count, drop_count, e.pkt, e.drop);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (scoreQ.size() > 0) checkOutput(scoreQ.pop_front());
        end
    end

    initial begin
        exp_t c;
        // Reset, then a normal 8-byte packet to port 2.
        applyStimulus(0, 0, 0, 0, 3'b111, 0, 0, 0, S_DA, 2'd0, "reset");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_DA, 2'd0, "idle");
        applyStimulus(1, 1, 2, 0, 3'b111, 0, 0, 0, S_LFD, 2'd2, "norm_lfd");
        for (int i = 0; i < 8; i++)
            applyStimulus(1, 1, 1, 0, 3'b111, 0, 0, 0, S_LD, 2'd2, "norm_ld");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_LP, 2'd2, "norm_lp");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_CPE, 2'd2, "norm_cpe");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_DA, 2'd2, "norm_done");
        // Reset mid-payload.
        applyStimulus(1, 1, 1, 0, 3'b111, 0, 0, 0, S_LFD, 2'd1, "rst_lfd");
        applyStimulus(1, 1, 0, 0, 3'b111, 0, 0, 0, S_LD, 2'd1, "rst_ld");
        applyStimulus(0, 1, 0, 0, 3'b111, 0, 0, 0, S_DA, 2'd0, "mid_reset");
        // Wait for FIFO 2 to drain, then fill up mid-payload and recover via low_packet_valid.
        applyStimulus(1, 1, 2, 0, 3'b011, 0, 0, 0, S_WTE, 2'd2, "wte_enter");
        applyStimulus(1, 1, 0, 0, 3'b011, 0, 0, 0, S_WTE, 2'd2, "wte_hold");
        applyStimulus(1, 1, 0, 0, 3'b111, 0, 0, 0, S_LFD, 2'd2, "wte_lfd");
        applyStimulus(1, 1, 0, 0, 3'b111, 0, 0, 0, S_LD, 2'd2, "wte_ld");
        applyStimulus(1, 1, 0, 1, 3'b111, 0, 0, 0, S_FFS, 2'd2, "full_enter");
        applyStimulus(1, 1, 0, 1, 3'b111, 0, 0, 0, S_FFS, 2'd2, "full_hold");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 1, S_LAF, 2'd2, "laf");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 1, S_LP, 2'd2, "laf_lp");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_CPE, 2'd2, "laf_cpe");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_DA, 2'd2, "laf_done");
        // Full with !packet_valid together (full wins), then parity_done out of LOAD_AFTER_FULL.
        applyStimulus(1, 1, 0, 0, 3'b111, 0, 0, 0, S_LFD, 2'd0, "pd_lfd");
        applyStimulus(1, 1, 0, 0, 3'b111, 0, 0, 0, S_LD, 2'd0, "pd_ld");
        applyStimulus(1, 0, 0, 1, 3'b111, 0, 0, 0, S_FFS, 2'd0, "full_prio");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_LAF, 2'd0, "pd_laf");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 1, 0, S_DA, 2'd0, "pd_done");
        // Full seen in CHECK_PARITY_ERROR, then LOAD_AFTER_FULL falling back to LOAD_DATA.
        applyStimulus(1, 1, 1, 0, 3'b111, 0, 0, 0, S_LFD, 2'd1, "cpe_lfd");
        applyStimulus(1, 1, 0, 0, 3'b111, 0, 0, 0, S_LD, 2'd1, "cpe_ld");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_LP, 2'd1, "cpe_lp");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_CPE, 2'd1, "cpe");
        applyStimulus(1, 0, 0, 1, 3'b111, 0, 0, 0, S_FFS, 2'd1, "cpe_full");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_LAF, 2'd1, "cpe_laf");
        applyStimulus(1, 1, 0, 0, 3'b111, 0, 0, 0, S_LD, 2'd1, "laf_back_ld");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_LP, 2'd1, "cpe2_lp");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_CPE, 2'd1, "cpe2");
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_DA, 2'd1, "cpe2_done");
        // Soft reset: other port ignored, selected port aborts, ignored while decoding.
        applyStimulus(1, 1, 2, 0, 3'b111, 0, 0, 0, S_LFD, 2'd2, "sr_lfd");
        applyStimulus(1, 1, 0, 0, 3'b111, 0, 0, 0, S_LD, 2'd2, "sr_ld");
        applyStimulus(1, 1, 0, 0, 3'b111, 3'b001, 0, 0, S_LD, 2'd2, "sr_other");
        applyStimulus(1, 1, 0, 0, 3'b111, 3'b100, 0, 0, S_DA, 2'd2, "sr_sel");
        applyStimulus(1, 0, 0, 0, 3'b111, 3'b100, 0, 0, S_DA, 2'd2, "sr_in_da");
        // Invalid address is dropped.
        applyStimulus(1, 1, 3, 0, 3'b111, 0, 0, 0, S_DA, 2'd2, "invalid1");
        applyStimulus(1, 1, 3, 0, 3'b111, 0, 0, 0, S_DA, 2'd2, "invalid2");
`ifdef ROUTER_FSM_PKT_CNT_EN
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_DA, 2'd2, "counters");
        c = scoreQ.pop_back();
        c.chkCnt = 1'b1;
        c.pkt = 16'd4;
        c.drop = 8'd2;
        scoreQ.push_back(c);
`else
        applyStimulus(1, 0, 0, 0, 3'b111, 0, 0, 0, S_DA, 2'd2, "final_idle");
        c.chkCnt = 1'b0;
`endif
        repeat (3) @(posedge clk);
        checks++;
        if (scoreQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending expected 0", scoreQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
